// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, control bit map, opcode classes.
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      StFetch     = 3'd0,
      StDecode    = 3'd1,
      StExecute   = 3'd2,
      StMemory    = 3'd3,
      StWriteback = 3'd4,
      StHalt      = 3'd5,
      StFault     = 3'd6
   } state_e;

   localparam int unsigned CtrlPcWe    = 0;
   localparam int unsigned CtrlIrWe    = 1;
   localparam int unsigned CtrlRfRe    = 2;
   localparam int unsigned CtrlAluEn   = 3;
   localparam int unsigned CtrlMemRe   = 4;
   localparam int unsigned CtrlMemWe   = 5;
   localparam int unsigned CtrlRfWe    = 6;
   localparam int unsigned CtrlPcSelBr = 7;

   localparam logic [3:0] OpcLoad   = 4'h8;
   localparam logic [3:0] OpcStore  = 4'h9;
   localparam logic [3:0] OpcBranch = 4'hA;
   localparam logic [3:0] OpcJump   = 4'hB;
   localparam logic [3:0] OpcNop    = 4'hE;
   localparam logic [3:0] OpcHalt   = 4'hF;

   typedef enum logic [2:0] {
      ClsAlu     = 3'd0,
      ClsLoad    = 3'd1,
      ClsStore   = 3'd2,
      ClsBranch  = 3'd3,
      ClsJump    = 3'd4,
      ClsNop     = 3'd5,
      ClsHalt    = 3'd6,
      ClsIllegal = 3'd7
   } opc_class_e;

   // wide flags any set opcode bit above bit 3
   function automatic opc_class_e decode_class(logic [3:0] nib, logic wide);
      if (wide) return ClsIllegal;
      if (!nib[3]) return ClsAlu;
      case (nib)
         OpcLoad:   return ClsLoad;
         OpcStore:  return ClsStore;
         OpcBranch: return ClsBranch;
         OpcJump:   return ClsJump;
         OpcNop:    return ClsNop;
         OpcHalt:   return ClsHalt;
         default:   return ClsIllegal;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Bundle between the control FSM (master) and IR/memory/datapath (slave).
interface multicycle_ctrl_fsm_if #(
   parameter int unsigned OPC_W    = 4,
   parameter int unsigned RETIRE_W = 16
);
   logic [OPC_W-1:0]    opcode;
   logic                mem_ready;
   logic                branch_taken;
   logic [2:0]          state;
   logic [7:0]          control_signals;
   logic                instr_done;
   logic [RETIRE_W-1:0] retired_count;
   logic                halted;
   logic                fault;

   modport master (
      input  opcode, mem_ready, branch_taken,
      output state, control_signals, instr_done, retired_count, halted, fault
   );

   modport slave (
      output opcode, mem_ready, branch_taken,
      input  state, control_signals, instr_done, retired_count, halted, fault
   );
endinterface

// File: rtl/multicycle_ctrl_fsm_mem_wait_timer.sv
// Counts consecutive memory-wait cycles; terminal flags the last cycle allowed before timeout.
module mem_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic count_en,
   output logic terminal
);
   localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CntW-1:0] Last = (MEM_TIMEOUT > 0) ? CntW'(MEM_TIMEOUT - 1) : '0;

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (count_en) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // MEM_TIMEOUT of zero disables the timeout entirely
   assign terminal = (MEM_TIMEOUT > 0) && (cnt_q == Last);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle instruction sequencer: opcode-dependent paths, memory handshake with timeout,
// HALT/FAULT terminal states and a retired-instruction counter.
module multicycle_ctrl_fsm
   import multicycle_ctrl_pkg::*;
#(
   parameter int unsigned OPC_W       = 4,
   parameter int unsigned RETIRE_W    = 16,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input logic                  clk,
   input logic                  reset_n,
   multicycle_ctrl_fsm_if.master bus
);
   state_e              state_q, state_d;
   opc_class_e          opc_q, opc_d;
   logic                retire;
   logic                instr_done_q;
   logic [RETIRE_W-1:0] retired_q;
   logic                halted_q, fault_q;
   logic                wide_nz;
   logic                mem_wait, timeout, terminal;
   logic [7:0]          ctrl;
   logic [OPC_W-1:0]    opcode;

   assign opcode = bus.opcode;

   if (OPC_W > 4) begin : g_wide
      assign wide_nz = |opcode[OPC_W-1:4];
   end else begin : g_narrow
      assign wide_nz = 1'b0;
   end

   assign mem_wait = (state_q == StFetch) || (state_q == StMemory);
   assign timeout  = terminal && !bus.mem_ready;

   mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (state_d != state_q),
      .count_en(mem_wait && !bus.mem_ready),
      .terminal(terminal)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StFetch;
         opc_q        <= ClsAlu;
         instr_done_q <= 1'b0;
         retired_q    <= '0;
         halted_q     <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         opc_q        <= opc_d;
         instr_done_q <= retire;
         retired_q    <= retired_q + RETIRE_W'(retire);
         halted_q     <= (state_d == StHalt);
         fault_q      <= (state_d == StFault);
      end
   end

   always_comb begin
      state_d = state_q;
      opc_d   = opc_q;
      retire  = 1'b0;
      case (state_q)
         StFetch: begin
            if (bus.mem_ready)  state_d = StDecode;
            else if (timeout)   state_d = StFault;
         end
         StDecode: begin
            opc_d = decode_class(opcode[3:0], wide_nz);
            case (opc_d)
               ClsIllegal: state_d = StFault;
               ClsHalt:    state_d = StHalt;
               ClsNop: begin
                  state_d = StFetch;
                  retire  = 1'b1;
               end
               default:    state_d = StExecute;
            endcase
         end
         StExecute: begin
            case (opc_q)
               ClsBranch: begin
                  state_d = StFetch;
                  retire  = 1'b1;
               end
               ClsAlu, ClsJump:   state_d = StWriteback;
               ClsLoad, ClsStore: state_d = StMemory;
               default:           state_d = StFault;
            endcase
         end
         StMemory: begin
            if (bus.mem_ready) begin
               if (opc_q == ClsLoad) begin
                  state_d = StWriteback;
               end else begin
                  state_d = StFetch;
                  retire  = 1'b1;
               end
            end else if (timeout) begin
               state_d = StFault;
            end
         end
         StWriteback: begin
            state_d = StFetch;
            retire  = 1'b1;
         end
         StHalt:  state_d = StHalt;
         StFault: state_d = StFault;
         default: state_d = StFault;
      endcase
   end

   always_comb begin
      ctrl = '0;
      case (state_q)
         StFetch: begin
            ctrl[CtrlMemRe] = 1'b1;
            ctrl[CtrlPcWe]  = bus.mem_ready;
            ctrl[CtrlIrWe]  = bus.mem_ready;
         end
         StDecode: ctrl[CtrlRfRe] = 1'b1;
         StExecute: begin
            ctrl[CtrlAluEn] = 1'b1;
            if (opc_q == ClsBranch) begin
               ctrl[CtrlPcSelBr] = 1'b1;
               ctrl[CtrlPcWe]    = bus.branch_taken;
            end else if (opc_q == ClsJump) begin
               ctrl[CtrlPcSelBr] = 1'b1;
               ctrl[CtrlPcWe]    = 1'b1;
            end
         end
         StMemory: begin
            ctrl[CtrlMemRe] = (opc_q == ClsLoad);
            ctrl[CtrlMemWe] = (opc_q == ClsStore);
         end
         StWriteback: ctrl[CtrlRfWe] = 1'b1;
         default: ctrl = '0;
      endcase
   end

   assign bus.state           = state_q;
   assign bus.control_signals = ctrl;
   assign bus.instr_done      = instr_done_q;
   assign bus.retired_count   = retired_q;
   assign bus.halted          = halted_q;
   assign bus.fault           = fault_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Trace-based bench: instruction descriptors expand into per-cycle expected outputs and inputs.
module tb_multicycle_ctrl_fsm;
   localparam int unsigned OPC_W       = 5;
   localparam int unsigned RETIRE_W    = 3;
   localparam int unsigned MEM_TIMEOUT = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   multicycle_ctrl_fsm_if #(.OPC_W(OPC_W), .RETIRE_W(RETIRE_W)) bus ();

   multicycle_ctrl_fsm #(
      .OPC_W      (OPC_W),
      .RETIRE_W   (RETIRE_W),
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   typedef struct {
      bit               rst;
      bit               mr;
      bit               br;
      logic [OPC_W-1:0] op;
      int               st;
      int               ctrl;
      bit               done;
   } rec_t;

   rec_t q[$];
   bit   pend = 1'b0;
   int   n_chk = 0, n_pass = 0;
   int   log_st[$], log_ctrl[$], log_done[$], log_cnt[$], log_halt[$];
   int   nop_idx, halt_idx;

   function automatic bit rb();
      return bit'($urandom_range(0, 1));
   endfunction

   function automatic logic [OPC_W-1:0] junk();
      return OPC_W'($urandom);
   endfunction

   task automatic push(int st, int ctrl, bit mr, bit br, logic [OPC_W-1:0] op, bit rst);
      rec_t r;
      r.rst = rst; r.mr = mr; r.br = br; r.op = op; r.st = st; r.ctrl = ctrl;
      r.done = pend && (st == 0) && !rst;
      if (st == 0 || rst) pend = 1'b0;
      q.push_back(r);
   endtask

   task automatic do_reset(bit mr);
      push(0, mr ? 'h13 : 'h10, mr, rb(), junk(), 1'b1);
   endtask

   task automatic terminal(int st, int n);
      repeat (n) push(st, 'h00, rb(), rb(), junk(), 1'b0);
   endtask

   // w low cycles then ready; returns 1 if the wait runs into the timeout
   task automatic mem_phase(int st, int busy_ctrl, int done_ctrl, int w, output bit faulted);
      faulted = 1'b0;
      for (int i = 0; i < w && i < int'(MEM_TIMEOUT); i++) push(st, busy_ctrl, 1'b0, rb(), junk(), 1'b0);
      if (w >= int'(MEM_TIMEOUT)) begin
         faulted = 1'b1;
         terminal(6, 3);
         do_reset(1'b0);
      end else begin
         push(st, done_ctrl, 1'b1, rb(), junk(), 1'b0);
      end
   endtask

   // 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 NOP, 6 HALT, 7 ILLEGAL
   function automatic int klass(logic [OPC_W-1:0] op);
      if ((op >> 4) != 0) return 7;
      if (op < 8) return 0;
      case (int'(op))
         8: return 1;
         9: return 2;
         10: return 3;
         11: return 4;
         14: return 5;
         15: return 6;
         default: return 7;
      endcase
   endfunction

   task automatic instr(logic [OPC_W-1:0] op, int fw, int mw, bit br);
      bit f;
      mem_phase(0, 'h10, 'h13, fw, f);
      if (f) return;
      push(1, 'h04, rb(), rb(), op, 1'b0);
      case (klass(op))
         0: begin push(2, 'h08, rb(), rb(), junk(), 0); push(4, 'h40, rb(), rb(), junk(), 0); pend = 1; end
         1: begin
            push(2, 'h08, rb(), rb(), junk(), 0);
            mem_phase(3, 'h10, 'h10, mw, f);
            if (!f) begin push(4, 'h40, rb(), rb(), junk(), 0); pend = 1; end
         end
         2: begin
            push(2, 'h08, rb(), rb(), junk(), 0);
            mem_phase(3, 'h20, 'h20, mw, f);
            if (!f) pend = 1;
         end
         3: begin push(2, br ? 'h89 : 'h88, rb(), br, junk(), 0); pend = 1; end
         4: begin push(2, 'h89, rb(), rb(), junk(), 0); push(4, 'h40, rb(), rb(), junk(), 0); pend = 1; end
         5: pend = 1;
         6: begin halt_idx = q.size(); terminal(5, 20); do_reset(1'b0); end
         default: begin terminal(6, 3); do_reset(1'b1); end
      endcase
   endtask

   task automatic chk(string name, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic build();
      do_reset(1'b0);
      do_reset(1'b1);
      instr(5'h03, 0, 0, 0);
      instr(5'h08, 1, 3, 0);
      instr(5'h09, 0, 2, 0);
      instr(5'h0A, 0, 0, 1);
      instr(5'h0A, 2, 0, 0);
      instr(5'h0B, 0, 0, 0);
      instr(5'h0E, 0, 0, 0);
      instr(5'h07, 1, 0, 0);
      instr(5'h00, 4, 0, 0);  // fetch timeout
      instr(5'h0F, 0, 0, 0);
      instr(5'h0C, 0, 0, 0);
      instr(5'h0D, 1, 0, 0);
      instr(5'h13, 0, 0, 0);  // wide bit set
      instr(5'h08, 0, 4, 0);  // memory timeout
      instr(5'h09, 0, 3, 0);
      do_reset(1'b0);
      repeat (9) instr(5'h0E, 0, 0, 0);
      nop_idx = q.size();
      // reset asserted mid-MEMORY of a load
      push(0, 'h13, 1, rb(), junk(), 0);
      push(1, 'h04, rb(), rb(), 5'h08, 0);
      push(2, 'h08, rb(), rb(), junk(), 0);
      push(3, 'h10, 0, rb(), junk(), 0);
      push(3, 'h10, 0, rb(), junk(), 0);
      do_reset(1'b1);
      instr(5'h05, 0, 0, 0);
      push(0, 'h10, 0, rb(), junk(), 0);
   endtask

   initial begin
      int exp_cnt;
      int lit_st[5]   = '{0, 1, 2, 4, 0};
      int lit_ctrl[4] = '{'h13, 'h04, 'h08, 'h40};
      exp_cnt = 0;
      bus.mem_ready = 1'b0;
      bus.branch_taken = 1'b0;
      bus.opcode = '0;
      build();
      foreach (q[i]) begin
         @(negedge clk);
         bus.mem_ready    = q[i].mr;
         bus.branch_taken = q[i].br;
         bus.opcode       = q[i].op;
         reset_n          = !q[i].rst;
         if (q[i].rst) exp_cnt = 0;
         else if (q[i].done) exp_cnt = (exp_cnt + 1) % (1 << RETIRE_W);
         #1;
         chk($sformatf("state[%0d]", i), int'(bus.state), q[i].st);
         chk($sformatf("control[%0d]", i), int'(bus.control_signals), q[i].ctrl);
         chk($sformatf("instr_done[%0d]", i), int'(bus.instr_done), int'(q[i].done));
         chk($sformatf("retired_count[%0d]", i), int'(bus.retired_count), exp_cnt);
         chk($sformatf("halted[%0d]", i), int'(bus.halted), int'(q[i].st == 5));
         chk($sformatf("fault[%0d]", i), int'(bus.fault), int'(q[i].st == 6));
         log_st.push_back(int'(bus.state));
         log_ctrl.push_back(int'(bus.control_signals));
         log_done.push_back(int'(bus.instr_done));
         log_cnt.push_back(int'(bus.retired_count));
         log_halt.push_back(int'(bus.halted));
      end
      // literal pins on the first ALU instruction, reset decode, NOP wrap and HALT stickiness
      chk("reset_ctrl_mr0", log_ctrl[0], 'h10);
      chk("reset_ctrl_mr1", log_ctrl[1], 'h13);
      for (int k = 0; k < 5; k++) chk($sformatf("alu_state_%0d", k), log_st[2 + k], lit_st[k]);
      for (int k = 0; k < 4; k++) chk($sformatf("alu_ctrl_%0d", k), log_ctrl[2 + k], lit_ctrl[k]);
      chk("alu_done", log_done[6], 1);
      chk("alu_count", log_cnt[6], 1);
      chk("nop_wrap_count", log_cnt[nop_idx], 1);
      chk("halt_sticky", log_halt[halt_idx + 19], 1);
      chk("halt_state", log_st[halt_idx + 19], 5);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
